// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port GPR array with a bulk-clear engine.
//
// Two write ports (port 1 wins on an address collision), NRD combinational
// read ports, optional hardwired-zero R0, optional same-cycle write->read
// bypass. The clear engine walks the array one register per cycle.
//
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   we0, waddr0, wdata0         write port 0
//   we1, waddr1, wdata1         write port 1 (priority)
//   raddr [NRD*ADDR_W]          read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata [NRD*DATA_W]          read data,      port k at [k*DATA_W +: DATA_W]
//   clr_req                     start bulk clear (taken in IDLE only)
//   clr_busy                    clear engine walking the array
//   clr_done                    one-cycle pulse after the last register clears

// Read port: out-of-range and hardwired R0 read zero. The write enables seen
// here are already filtered (range, R0, clear-busy), so a plain address match
// is enough for the bypass.
module regfile_mp_rd #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic [NREG-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]           raddr,
  input  logic [1:0]                  wen,
  input  logic [1:0][ADDR_W-1:0]      waddr,
  input  logic [1:0][DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]           rdata
);
  logic in_range, is_r0;

  assign in_range = {1'b0, raddr} < (ADDR_W+1)'(NREG);
  assign is_r0    = ZERO_R0 && (raddr == '0);

  always_comb begin
    rdata = '0;
    if (in_range && !is_r0) begin
      rdata = regs[raddr];
      if (BYPASS) begin
        if (wen[0] && waddr[0] == raddr) rdata = wdata[0];
        if (wen[1] && waddr[1] == raddr) rdata = wdata[1];
      end
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG-1);

  state_t                     state;
  logic [ADDR_W-1:0]          cnt;
  logic [NREG-1:0][DATA_W-1:0] regs;
  wr_req_t [1:0]              wr;
  logic [1:0]                 wen;
  logic [1:0][ADDR_W-1:0]     waddr;
  logic [1:0][DATA_W-1:0]     wdata;

  // A write is accepted only when in range, not aimed at a hardwired R0 and
  // the clear engine is not walking the array.
  function automatic logic accept(input logic we, input logic [ADDR_W-1:0] a,
                                  input logic busy);
    return we && !busy && ({1'b0, a} < (ADDR_W+1)'(NREG)) &&
           !(ZERO_R0 && a == '0);
  endfunction

  assign wr[0] = '{en: accept(we0, waddr0, clr_busy), addr: waddr0, data: wdata0};
  assign wr[1] = '{en: accept(we1, waddr1, clr_busy), addr: waddr1, data: wdata1};

  for (genvar p = 0; p < 2; p++) begin : g_wr
    assign wen[p]   = wr[p].en;
    assign waddr[p] = wr[p].addr;
    assign wdata[p] = wr[p].data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: if (clr_req) begin
          state    <= CLEAR;
          cnt      <= '0;
          clr_busy <= 1'b1;
        end
        CLEAR: begin
          regs[cnt] <= '0;
          if (cnt == LAST) begin
            // counter parks at the last index rather than wrapping
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Port 1 is applied last so it wins a same-address collision.
      // Writes never overlap the clear walk (accept() gates on clr_busy).
      if (wr[0].en) regs[wr[0].addr] <= wr[0].data;
      if (wr[1].en) regs[wr[1].addr] <= wr[1].data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rd #(
      .DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W),
      .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
    ) u_rd (
      .regs  (regs),
      .raddr (raddr[k*ADDR_W +: ADDR_W]),
      .wen   (wen),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp.
// Three instances: a = defaults (32 regs, R0 zero, bypass), b = 16 regs,
// 4 read ports, ordinary R0, no bypass; c = 12 regs behind 4-bit addresses
// (out-of-range coverage), shares b's stimulus, bypass on.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we0_a = 0, we1_a = 0, clr_req_a = 0, clr_busy_a, clr_done_a;
  logic [4:0]  waddr0_a = 0, waddr1_a = 0;
  logic [31:0] wdata0_a = 0, wdata1_a = 0;
  logic [9:0]  raddr_a = 0;
  logic [63:0] rdata_a;

  logic        we0_b = 0, we1_b = 0, clr_req_b = 0, clr_busy_b, clr_done_b;
  logic [3:0]  waddr0_b = 0, waddr1_b = 0;
  logic [31:0] wdata0_b = 0, wdata1_b = 0;
  logic [15:0] raddr_b = 0;
  logic [127:0] rdata_b;
  logic [31:0] rdata_c;
  logic        clr_busy_c, clr_done_c;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0_a), .waddr0(waddr0_a), .wdata0(wdata0_a),
    .we1(we1_a), .waddr1(waddr1_a), .wdata1(wdata1_a),
    .raddr(raddr_a), .rdata(rdata_a),
    .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a));

  regfile_mp #(.NREG(16), .ADDR_W(4), .NRD(4), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
    .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
    .raddr(raddr_b), .rdata(rdata_b),
    .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b));

  regfile_mp #(.NREG(12), .ADDR_W(4), .NRD(1), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
    .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
    .raddr(raddr_b[3:0]), .rdata(rdata_c),
    .clr_req(clr_req_b), .clr_busy(clr_busy_c), .clr_done(clr_done_c));

  // ---------------- reference model ----------------
  // cp[m]: -1 idle, 0..nreg-1 = index being cleared this cycle, nreg = done.
  int          nreg_m[3] = '{32, 16, 12};
  bit          z0_m[3]   = '{1'b1, 1'b0, 1'b0};
  bit          byp_m[3]  = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mem[3][32];
  int          cp[3];
  int          bcnt[3], dcnt[3];
  int          nvec = 0, nerr = 0;

  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      cp[m] = -1;
      for (int r = 0; r < 32; r++) mem[m][r] = '0;
    end
  endfunction

  function automatic bit m_busy(int m);
    return cp[m] >= 0 && cp[m] < nreg_m[m];
  endfunction

  function automatic bit m_done(int m);
    return cp[m] == nreg_m[m];
  endfunction

  function automatic bit m_ok(int m, bit e, int a);
    return e && !m_busy(m) && a < nreg_m[m] && !(z0_m[m] && a == 0);
  endfunction

  function automatic void model_edge(int m, bit e0, int a0, logic [31:0] d0,
                                     bit e1, int a1, logic [31:0] d1, bit cr);
    bit ok0 = m_ok(m, e0, a0);
    bit ok1 = m_ok(m, e1, a1);
    if (ok0) mem[m][a0] = d0;
    if (ok1) mem[m][a1] = d1;
    if (cp[m] == -1) begin
      if (cr) cp[m] = 0;
    end else if (cp[m] < nreg_m[m]) begin
      mem[m][cp[m]] = '0;
      cp[m]++;
    end else cp[m] = -1;
  endfunction

  function automatic logic [31:0] exp_rd(int m, int ra, bit e0, int a0, logic [31:0] d0,
                                         bit e1, int a1, logic [31:0] d1);
    if (ra >= nreg_m[m] || (z0_m[m] && ra == 0)) return '0;
    if (byp_m[m]) begin
      if (m_ok(m, e1, a1) && a1 == ra) return d1;
      if (m_ok(m, e0, a0) && a0 == ra) return d0;
    end
    return mem[m][ra];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output of every instance against the model, 1 time unit
  // after inputs were driven (well clear of both clock edges).
  task automatic check_all();
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("a.rd%0d[%0d]", k, raddr_a[k*5 +: 5]), rdata_a[k*32 +: 32],
          exp_rd(0, int'(raddr_a[k*5 +: 5]), we0_a, int'(waddr0_a), wdata0_a,
                 we1_a, int'(waddr1_a), wdata1_a));
    for (int k = 0; k < 4; k++)
      chk($sformatf("b.rd%0d[%0d]", k, raddr_b[k*4 +: 4]), rdata_b[k*32 +: 32],
          exp_rd(1, int'(raddr_b[k*4 +: 4]), we0_b, int'(waddr0_b), wdata0_b,
                 we1_b, int'(waddr1_b), wdata1_b));
    chk($sformatf("c.rd0[%0d]", raddr_b[3:0]), rdata_c,
        exp_rd(2, int'(raddr_b[3:0]), we0_b, int'(waddr0_b), wdata0_b,
               we1_b, int'(waddr1_b), wdata1_b));
    chk("a.busy", 32'(clr_busy_a), 32'(m_busy(0)));
    chk("a.done", 32'(clr_done_a), 32'(m_done(0)));
    chk("b.busy", 32'(clr_busy_b), 32'(m_busy(1)));
    chk("b.done", 32'(clr_done_b), 32'(m_done(1)));
    chk("c.busy", 32'(clr_busy_c), 32'(m_busy(2)));
    chk("c.done", 32'(clr_done_c), 32'(m_done(2)));
    if (clr_busy_a) bcnt[0]++;
    if (clr_busy_b) bcnt[1]++;
    if (clr_busy_c) bcnt[2]++;
    if (clr_done_a) dcnt[0]++;
    if (clr_done_b) dcnt[1]++;
    if (clr_done_c) dcnt[2]++;
  endtask

  task automatic tick();
    model_edge(0, we0_a, int'(waddr0_a), wdata0_a, we1_a, int'(waddr1_a), wdata1_a, clr_req_a);
    for (int m = 1; m < 3; m++)
      model_edge(m, we0_b, int'(waddr0_b), wdata0_b, we1_b, int'(waddr1_b), wdata1_b, clr_req_b);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    check_all();
    tick();
  endtask

  task automatic idle_inputs();
    we0_a = 0; we1_a = 0; clr_req_a = 0;
    we0_b = 0; we1_b = 0; clr_req_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    check_all();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic clr_counts();
    for (int m = 0; m < 3; m++) begin bcnt[m] = 0; dcnt[m] = 0; end
  endtask

  task automatic rand_inputs();
    we0_a = 1'($urandom); we1_a = 1'($urandom);
    waddr0_a = 5'($urandom); waddr1_a = 5'($urandom);
    if ($urandom_range(0, 7) == 0) waddr1_a = waddr0_a;
    wdata0_a = $urandom; wdata1_a = $urandom;
    raddr_a = 10'($urandom);
    if ($urandom_range(0, 3) == 0) raddr_a[4:0] = waddr1_a;
    if ($urandom_range(0, 3) == 0) raddr_a[9:5] = waddr0_a;
    clr_req_a = ($urandom_range(0, 49) == 0);
    we0_b = 1'($urandom); we1_b = 1'($urandom);
    waddr0_b = 4'($urandom); waddr1_b = 4'($urandom);
    if ($urandom_range(0, 7) == 0) waddr1_b = waddr0_b;
    wdata0_b = $urandom; wdata1_b = $urandom;
    raddr_b = 16'($urandom);
    if ($urandom_range(0, 3) == 0) raddr_b[3:0] = waddr1_b;
    clr_req_b = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    model_reset();
    clr_counts();
    #1;
    check_all();
    rst_n = 1'b1;
    tick();

    // reset clears stored data
    we0_a = 1; waddr0_a = 5; wdata0_a = 32'hDEADBEEF; cyc();
    we0_a = 0; raddr_a = {5'd5, 5'd5};
    check_all();
    chk("r5_written", rdata_a[31:0], 32'hDEADBEEF);
    do_reset();
    chk("r5_after_rst", rdata_a[31:0], 32'h0);
    chk("busy_after_rst", 32'(clr_busy_a), 32'h0);
    tick();

    // dual write, distinct then colliding addresses
    we0_a = 1; waddr0_a = 3; wdata0_a = 32'h11;
    we1_a = 1; waddr1_a = 7; wdata1_a = 32'h22; cyc();
    waddr0_a = 9; wdata0_a = 32'hAA; waddr1_a = 9; wdata1_a = 32'hBB;
    raddr_a = {5'd7, 5'd3};
    check_all();
    chk("r3_dual", rdata_a[31:0], 32'h11);
    chk("r7_dual", rdata_a[63:32], 32'h22);
    tick();
    we0_a = 0; we1_a = 0; raddr_a = {5'd9, 5'd9};
    check_all();
    chk("r9_collide", rdata_a[31:0], 32'hBB);
    tick();

    // R0 hardwired, never bypassed; bypass of r4
    we0_a = 1; waddr0_a = 0; wdata0_a = 32'hFFFF_FFFF; raddr_a = '0;
    check_all();
    chk("r0_bypass", rdata_a[31:0], 32'h0);
    tick();
    we0_a = 0; check_all();
    chk("r0_stored", rdata_a[31:0], 32'h0);
    tick();
    we1_a = 1; waddr1_a = 4; wdata1_a = 32'h1234; raddr_a = {5'd4, 5'd4};
    check_all();
    chk("r4_bypass", rdata_a[31:0], 32'h1234);
    tick();
    we1_a = 0;

    // dut_b: four distinct reads, ordinary R0
    we0_b = 1; waddr0_b = 0; wdata0_b = 32'h77;
    we1_b = 1; waddr1_b = 1; wdata1_b = 32'h101; cyc();
    waddr0_b = 2; wdata0_b = 32'h202; waddr1_b = 3; wdata1_b = 32'h303; cyc();
    we0_b = 0; we1_b = 0; raddr_b = {4'd3, 4'd2, 4'd1, 4'd0};
    check_all();
    chk("b_r0", rdata_b[31:0], 32'h77);
    chk("b_r1", rdata_b[63:32], 32'h101);
    chk("b_r2", rdata_b[95:64], 32'h202);
    chk("b_r3", rdata_b[127:96], 32'h303);
    chk("c_r0", rdata_c, 32'h77);
    tick();

    // no bypass on b, bypass on c
    we0_b = 1; waddr0_b = 4; wdata0_b = 32'h1; cyc();
    we0_b = 0; we1_b = 1; waddr1_b = 4; wdata1_b = 32'h1234; raddr_b = 16'h0004;
    check_all();
    chk("b_nobyp_old", rdata_b[31:0], 32'h1);
    chk("c_byp", rdata_c, 32'h1234);
    tick();
    we1_b = 0; check_all();
    chk("b_nobyp_new", rdata_b[31:0], 32'h1234);
    tick();

    // out-of-range on c (12 regs)
    we0_b = 1; waddr0_b = 13; wdata0_b = 32'hCAFE; raddr_b = 16'h000D;
    check_all();
    chk("c_oor_byp", rdata_c, 32'h0);
    tick();
    we0_b = 0; check_all();
    chk("c_oor_rd", rdata_c, 32'h0);
    chk("b_r13", rdata_b[31:0], 32'hCAFE);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc();
    end
    idle_inputs();
    repeat (40) cyc();

    // full clear on a; write during busy dropped
    for (int i = 1; i < 32; i++) begin
      we0_a = 1; waddr0_a = 5'(i); wdata0_a = $urandom | 32'h1; raddr_a = 10'($urandom);
      cyc();
    end
    we0_a = 0;
    clr_counts();
    clr_req_a = 1; cyc(); clr_req_a = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        we1_a = 1; waddr1_a = 2; wdata1_a = 32'h55; raddr_a = {5'd2, 5'd2};
      end else begin
        we1_a = 0; raddr_a = 10'($urandom);
      end
      cyc();
    end
    chk("a_busy_len", 32'(bcnt[0]), 32'd32);
    chk("a_done_cnt", 32'(dcnt[0]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      raddr_a = {5'(2*i+1), 5'(2*i)};
      check_all();
      chk("a_cleared_lo", rdata_a[31:0], 32'h0);
      chk("a_cleared_hi", rdata_a[63:32], 32'h0);
      tick();
    end

    // reset during clear, then a full clear again
    for (int i = 1; i < 32; i++) begin
      we1_a = 1; waddr1_a = 5'(i); wdata1_a = $urandom | 32'h1; cyc();
    end
    we1_a = 0;
    clr_counts();
    clr_req_a = 1; cyc(); clr_req_a = 0;
    repeat (9) cyc();
    do_reset();
    tick();
    repeat (40) cyc();
    chk("a_no_done_after_rst", 32'(dcnt[0]), 32'd0);
    clr_counts();
    clr_req_a = 1; clr_req_b = 1; cyc(); idle_inputs();
    repeat (40) cyc();
    chk("a_busy_len2", 32'(bcnt[0]), 32'd32);
    chk("b_busy_len", 32'(bcnt[1]), 32'd16);
    chk("c_busy_len", 32'(bcnt[2]), 32'd12);
    chk("b_done_cnt", 32'(dcnt[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
